// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush consumer: owns PC, IF/ID and ID/EX control registers, sequences an
// ECALL halt through a fixed drain window and keeps stall/bubble performance counters.
module pipeline_stall_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int unsigned CTRL_W       = 16,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [31:0] NOP_INST     = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_write,
  input  logic              IF_ID_write,
  input  logic              ID_EX_sel,
  input  logic              flush,
  input  logic              mem_stall,
  input  logic [31:0]       next_pc,
  input  logic [31:0]       if_inst,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              halt_req,
  output logic [31:0]       current_pc,
  output logic [31:0]       IF_ID_inst,
  output logic [31:0]       IF_ID_pc,
  output logic              IF_ID_valid,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
  output logic              ID_EX_valid,
  output logic              is_halted,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       bubble_count
);

  // A zero-length drain degenerates to a single-cycle drain.
  localparam logic [31:0] DrainInit = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 32'd0;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         ifid_inst_q, ifid_inst_d;
  logic [31:0]         ifid_pc_q, ifid_pc_d;
  logic                ifid_valid_q, ifid_valid_d;
  logic [CTRL_W-1:0]   idex_ctrl_q, idex_ctrl_d;
  logic                idex_valid_q, idex_valid_d;
  logic                halted_q, halted_d;
  logic [31:0]         stall_cnt_q, stall_cnt_d;
  logic [31:0]         bubble_cnt_q, bubble_cnt_d;
  logic [31:0]         drain_cnt_q, drain_cnt_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    idex_ctrl_d  = idex_ctrl_q;
    idex_valid_d = idex_valid_q;
    halted_d     = halted_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    drain_cnt_d  = drain_cnt_q;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          // Whole front end frozen; hazard, flush and halt requests wait.
          stall_cnt_d = stall_cnt_q + 32'd1;
        end else if (flush) begin
          pc_d         = next_pc;
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
          idex_ctrl_d  = '0;
          idex_valid_d = 1'b0;
          bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else begin
          if (!pc_write) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
          end else begin
            pc_d = next_pc;
          end

          if (IF_ID_write) begin
            ifid_inst_d  = if_inst;
            ifid_pc_d    = pc_q;
            ifid_valid_d = 1'b1;
          end

          if (ID_EX_sel) begin
            idex_ctrl_d  = '0;
            idex_valid_d = 1'b0;
            bubble_cnt_d = bubble_cnt_q + 32'd1;
          end else begin
            idex_ctrl_d  = id_ctrl;
            idex_valid_d = ifid_valid_q;
          end

          // Halt moves into ID/EX as usual; fetch stops behind it.
          if (halt_req && ifid_valid_q && !ID_EX_sel) begin
            pc_d         = pc_q;
            ifid_inst_d  = NOP_INST;
            ifid_valid_d = 1'b0;
            drain_cnt_d  = DrainInit;
            state_d      = StDrain;
          end
        end
      end

      StDrain: begin
        if (mem_stall) begin
          stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
          idex_ctrl_d  = '0;
          idex_valid_d = 1'b0;
          bubble_cnt_d = bubble_cnt_q + 32'd1;
          if (drain_cnt_q == 32'd0) begin
            halted_d = 1'b1;
            state_d  = StHalted;
          end else begin
            drain_cnt_d = drain_cnt_q - 32'd1;
          end
        end
      end

      StHalted: begin
        // Everything holds until reset.
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      ifid_inst_q  <= NOP_INST;
      ifid_pc_q    <= 32'd0;
      ifid_valid_q <= 1'b0;
      idex_ctrl_q  <= '0;
      idex_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
      drain_cnt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      idex_ctrl_q  <= idex_ctrl_d;
      idex_valid_q <= idex_valid_d;
      halted_q     <= halted_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  assign current_pc   = pc_q;
  assign IF_ID_inst   = ifid_inst_q;
  assign IF_ID_pc     = ifid_pc_q;
  assign IF_ID_valid  = ifid_valid_q;
  assign ID_EX_ctrl   = idex_ctrl_q;
  assign ID_EX_valid  = idex_valid_q;
  assign is_halted    = halted_q;
  assign stall_cycles = stall_cnt_q;
  assign bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: free run, load-use stall, flush, memory stall,
// halt drain and reset recovery, with hand-computed expectations.
module tb_pipeline_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pc_write, IF_ID_write, ID_EX_sel, flush, mem_stall, halt_req;
  logic [31:0] next_pc, if_inst;
  logic [15:0] id_ctrl;
  logic [31:0] current_pc, IF_ID_inst, IF_ID_pc, stall_cycles, bubble_count;
  logic        IF_ID_valid, ID_EX_valid, is_halted;
  logic [15:0] ID_EX_ctrl;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .pc_write     (pc_write),
    .IF_ID_write  (IF_ID_write),
    .ID_EX_sel    (ID_EX_sel),
    .flush        (flush),
    .mem_stall    (mem_stall),
    .next_pc      (next_pc),
    .if_inst      (if_inst),
    .id_ctrl      (id_ctrl),
    .halt_req     (halt_req),
    .current_pc   (current_pc),
    .IF_ID_inst   (IF_ID_inst),
    .IF_ID_pc     (IF_ID_pc),
    .IF_ID_valid  (IF_ID_valid),
    .ID_EX_ctrl   (ID_EX_ctrl),
    .ID_EX_valid  (ID_EX_valid),
    .is_halted    (is_halted),
    .stall_cycles (stall_cycles),
    .bubble_count (bubble_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; pc_write = 1'b1; IF_ID_write = 1'b1; ID_EX_sel = 1'b0;
    flush = 1'b0; mem_stall = 1'b0; halt_req = 1'b0;
    next_pc = 32'h0; if_inst = 32'h00500093; id_ctrl = 16'hA5A5;
    step(); step();
    check("rst_pc", current_pc, 32'h0);
    check("rst_ifid_inst", IF_ID_inst, 32'h00000013);
    check("rst_ifid_pc", IF_ID_pc, 32'h0);
    check("rst_ifid_valid", IF_ID_valid, 0);
    check("rst_idex_ctrl", ID_EX_ctrl, 0);
    check("rst_idex_valid", ID_EX_valid, 0);
    check("rst_halted", is_halted, 0);
    check("rst_stall", stall_cycles, 0);
    check("rst_bubble", bubble_count, 0);

    // 1: four free-running cycles
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next_pc = 32'(i * 4 + 4);
      step();
    end
    check("run_pc", current_pc, 32'h10);
    check("run_ifid_pc", IF_ID_pc, 32'hC);
    check("run_ifid_valid", IF_ID_valid, 1);
    check("run_ifid_inst", IF_ID_inst, 32'h00500093);
    check("run_idex_ctrl", ID_EX_ctrl, 32'hA5A5);
    check("run_idex_valid", ID_EX_valid, 1);
    check("run_stall", stall_cycles, 0);
    check("run_bubble", bubble_count, 0);

    // 2: load-use stall
    pc_write = 1'b0; IF_ID_write = 1'b0; ID_EX_sel = 1'b1; next_pc = 32'h14;
    step();
    check("lu_pc", current_pc, 32'h10);
    check("lu_ifid_pc", IF_ID_pc, 32'hC);
    check("lu_ifid_inst", IF_ID_inst, 32'h00500093);
    check("lu_idex_ctrl", ID_EX_ctrl, 0);
    check("lu_idex_valid", ID_EX_valid, 0);
    check("lu_stall", stall_cycles, 1);
    check("lu_bubble", bubble_count, 1);

    // 3: flush redirect
    pc_write = 1'b1; IF_ID_write = 1'b1; ID_EX_sel = 1'b0;
    flush = 1'b1; next_pc = 32'h40;
    step();
    check("fl_pc", current_pc, 32'h40);
    check("fl_ifid_inst", IF_ID_inst, 32'h00000013);
    check("fl_ifid_valid", IF_ID_valid, 0);
    check("fl_idex_valid", ID_EX_valid, 0);
    check("fl_bubble", bubble_count, 2);
    check("fl_stall", stall_cycles, 1);

    // 4: mem_stall masks a pending flush
    flush = 1'b0; next_pc = 32'h44;
    step();
    check("pre_ms_pc", current_pc, 32'h44);
    check("pre_ms_ifid_valid", IF_ID_valid, 1);
    mem_stall = 1'b1; flush = 1'b1; next_pc = 32'h80;
    for (int i = 0; i < 3; i++) step();
    check("ms_pc", current_pc, 32'h44);
    check("ms_ifid_pc", IF_ID_pc, 32'h40);
    check("ms_ifid_valid", IF_ID_valid, 1);
    check("ms_stall", stall_cycles, 4);
    check("ms_bubble", bubble_count, 2);
    mem_stall = 1'b0;
    step();
    check("ms_fl_pc", current_pc, 32'h80);
    check("ms_fl_ifid_valid", IF_ID_valid, 0);
    check("ms_fl_bubble", bubble_count, 3);

    // 5: halt and drain
    flush = 1'b0; next_pc = 32'h84;
    step();
    check("h_pre_ifid_valid", IF_ID_valid, 1);
    check("h_pre_ifid_pc", IF_ID_pc, 32'h80);
    halt_req = 1'b1; id_ctrl = 16'h0ECA; next_pc = 32'h88;
    step();
    check("h_idex_valid", ID_EX_valid, 1);
    check("h_idex_ctrl", ID_EX_ctrl, 32'h0ECA);
    check("h_pc", current_pc, 32'h84);
    check("h_ifid_valid", IF_ID_valid, 0);
    check("h_halted0", is_halted, 0);
    halt_req = 1'b0; flush = 1'b1; next_pc = 32'h200;
    step();
    check("d1_halted", is_halted, 0);
    check("d1_pc", current_pc, 32'h84);
    check("d1_idex_valid", ID_EX_valid, 0);
    step();
    check("d2_halted", is_halted, 0);
    step();
    check("d3_halted", is_halted, 1);
    check("d3_pc", current_pc, 32'h84);
    check("d3_bubble", bubble_count, 6);
    flush = 1'b0; mem_stall = 1'b1;
    step();
    check("hl_halted", is_halted, 1);
    check("hl_bubble", bubble_count, 6);
    check("hl_stall", stall_cycles, 4);
    check("hl_pc", current_pc, 32'h84);

    // 6: reset mid-drain, then halt masked by flush
    mem_stall = 1'b0; reset = 1'b0;
    step();
    reset = 1'b1; next_pc = 32'h4;
    step();
    check("r_pc", current_pc, 32'h4);
    check("r_ifid_valid", IF_ID_valid, 1);
    halt_req = 1'b1; next_pc = 32'h8;
    step();
    check("r_drain_idex", ID_EX_valid, 1);
    halt_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("rd_halted", is_halted, 0);
    check("rd_pc", current_pc, 32'h0);
    check("rd_idex_valid", ID_EX_valid, 0);
    check("rd_bubble", bubble_count, 0);
    reset = 1'b1; next_pc = 32'h4;
    step();
    halt_req = 1'b1; flush = 1'b1; next_pc = 32'h100;
    step();
    check("hf_pc", current_pc, 32'h100);
    check("hf_ifid_valid", IF_ID_valid, 0);
    check("hf_idex_valid", ID_EX_valid, 0);
    halt_req = 1'b0; flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_pc = 32'h104 + 32'(i * 4);
      step();
    end
    check("hf_run_pc", current_pc, 32'h110);
    check("hf_run_halted", is_halted, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
